regfile_2r1w: RTL

//  General-purpose register file serving the decode stage: two combinational read

---
 rtl/cpu_defs_pkg.sv | 13 +
 rtl/regfile_2r1w.sv | 101 ++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// Constants and types shared by decode, write-back and the register file.
package cpu_defs_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = 5'd0;

  typedef enum logic [0:0] {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one synchronous write port, r0 optionally hard-wired to zero.
// A clear sweep after reset zeroes one entry per cycle, so storage needs no reset.
module regfile_2r1w
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned NREG    = 32,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG_ADDR);
  localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] mem [NREG];

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Pointer holds at the last entry, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else if (state_q == RF_CLEAR) begin
      if (clr_ptr_q == LastPtr) begin
        state_q <= RF_RUN;
      end else begin
        clr_ptr_q <= clr_ptr_q + 1'b1;
      end
    end
  end

  assign init_busy = rst | (state_q == RF_CLEAR);

  // Single write port into storage: clear sweep wins over write-back.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
      end else if (we && (ZERO_R0 == 0 || waddr != ZeroAddr)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // init_busy low implies RUN and rst low, so the bypass needs no extra state qualifier.
  function automatic logic [DATA_W-1:0] read_mux(input logic              ren,
                                                 input logic [ADDR_W-1:0] raddr);
    logic [DATA_W-1:0] res;
    if (init_busy) begin
      res = '0;
    end else if (!ren) begin
      res = '0;
    end else if (ZERO_R0 != 0 && raddr == ZeroAddr) begin
      res = '0;
    end else if (we && waddr == raddr) begin
      res = wdata;
    end else begin
      res = mem[raddr];
    end
    return res;
  endfunction

  always_comb begin
    rdata1 = read_mux(re1, raddr1);
  end

  always_comb begin
    rdata2 = read_mux(re2, raddr2);
  end

endmodule
